// File: rtl/eq_mult_pkg.sv
// Shared definitions for the EQ serial multiply-accumulate datapath.
package eq_mult_pkg;

    // Operation modes; 2'b11 is reserved and executes as MUL.
    localparam logic [1:0] MODE_MUL  = 2'b00;
    localparam logic [1:0] MODE_MAC  = 2'b01;
    localparam logic [1:0] MODE_MSUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2
    } state_t;

    // Saturation bounds are built wide and truncated to the accumulator width by the user.
    localparam int BOUND_W = 128;

    function automatic logic [BOUND_W-1:0] sat_max(input int w, input bit is_signed);
        sat_max = is_signed ? ((BOUND_W'(1) << (w - 1)) - BOUND_W'(1))
                            : ((BOUND_W'(1) << w) - BOUND_W'(1));
    endfunction

    function automatic logic [BOUND_W-1:0] sat_min(input int w, input bit is_signed);
        sat_min = is_signed ? (BOUND_W'(1) << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/eq_serial_mac_if.sv
// Request/response bundle between the sequencer and the serial MAC.
interface eq_serial_mac_if #(
    parameter int SAMPLE_W = 24,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 48
);
    logic [SAMPLE_W-1:0] i_sample;
    logic [COEF_W-1:0]   i_coefficient;
    logic [1:0]          i_mode;
    logic                i_start;
    logic                i_clear;
    logic                o_ready;
    logic                o_done;
    logic [ACC_W-1:0]    o_result;
    logic                o_overflow;

    modport master (
        output i_sample, i_coefficient, i_mode, i_start, i_clear,
        input  o_ready, o_done, o_result, o_overflow
    );

    modport slave (
        input  i_sample, i_coefficient, i_mode, i_start, i_clear,
        output o_ready, o_done, o_result, o_overflow
    );
endinterface

// File: rtl/eq_serial_mult_core.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
module eq_serial_mult_core #(
    parameter int MCAND_W  = 24,
    parameter int MPLIER_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load,
    input  logic [MCAND_W-1:0]          i_mcand,
    input  logic [MPLIER_W-1:0]         i_mplier,
    output logic [MCAND_W+MPLIER_W-1:0] o_product,
    output logic                        o_done
);
    localparam int CNT_W  = $clog2(MPLIER_W + 1);
    localparam int PROD_W = MCAND_W + MPLIER_W;

    logic [CNT_W-1:0]   r_cnt;
    logic [PROD_W-1:0]  r_prod;
    logic [MCAND_W-1:0] r_mcand;
    logic               r_busy;
    logic [MCAND_W:0]   w_sum;

    // Upper field plus multiplicand, carry kept so it lands in the MSB after the shift.
    assign w_sum = {1'b0, r_prod[PROD_W-1:MPLIER_W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

    // Load operands, then shift-add once per cycle until the counter runs out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_busy  <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= CNT_W'(MPLIER_W);
            r_prod  <= {{MCAND_W{1'b0}}, i_mplier};
            r_mcand <= i_mcand;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_prod <= {w_sum, r_prod[MPLIER_W-1:1]};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1))
                r_busy <= 1'b0;
        end
    end

    // High during the cycle whose edge performs the final shift-add.
    assign o_done    = r_busy && (r_cnt == CNT_W'(1));
    assign o_product = r_prod;

endmodule

// File: rtl/eq_serial_mac.sv
// Serial signed/unsigned MAC: sign handling, accumulator, saturation and handshake.
module eq_serial_mac
    import eq_mult_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 48,
    parameter int SIGNED   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    eq_serial_mac_if.slave bus
);
    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam int XW     = ACC_W + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

    state_t              r_state, w_next;
    logic                w_ready, w_load, w_acc_en;
    logic                w_s_neg, w_c_neg;
    logic [SAMPLE_W-1:0] w_s_mag;
    logic [COEF_W-1:0]   w_c_mag;
    logic [PROD_W-1:0]   w_product;
    logic                w_core_done;
    logic                r_neg;
    logic [1:0]          r_mode;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic                r_done;
    logic [XW-1:0]       w_p_mag, w_p, w_acc_x, w_sum;
    logic                w_ovf;
    logic [ACC_W-1:0]    w_sat, w_acc_next;

    // Magnitudes are unsigned W-bit, so the most negative input maps to 2^(W-1) cleanly.
    assign w_s_neg = (SIGNED != 0) && bus.i_sample[SAMPLE_W-1];
    assign w_c_neg = (SIGNED != 0) && bus.i_coefficient[COEF_W-1];
    assign w_s_mag = w_s_neg ? -bus.i_sample : bus.i_sample;
    assign w_c_mag = w_c_neg ? -bus.i_coefficient : bus.i_coefficient;

    eq_serial_mult_core #(
        .MCAND_W  (SAMPLE_W),
        .MPLIER_W (COEF_W)
    ) u_core (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_load),
        .i_mcand   (w_s_mag),
        .i_mplier  (w_c_mag),
        .o_product (w_product),
        .o_done    (w_core_done)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_next = MULT;
            MULT:    if (w_core_done) w_next = ACC;
            ACC:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_ready  = (r_state == IDLE);
        w_load   = w_ready && bus.i_start;
        w_acc_en = (r_state == ACC);
    end

    // Accumulate in one extra bit so any single step's overflow is visible.
    always_comb begin
        w_p_mag = XW'(w_product);
        w_p     = r_neg ? -w_p_mag : w_p_mag;
        w_acc_x = (SIGNED != 0) ? {r_acc[ACC_W-1], r_acc} : {1'b0, r_acc};
        case (r_mode)
            MODE_MAC:  w_sum = w_acc_x + w_p;
            MODE_MSUB: w_sum = w_acc_x - w_p;
            default:   w_sum = w_p;
        endcase
        if (SIGNED != 0) begin
            w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            w_sat = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            // Unsigned: only MSUB can go below zero, only MAC can carry out.
            w_ovf = w_sum[ACC_W];
            w_sat = (r_mode == MODE_MSUB) ? SAT_MIN : SAT_MAX;
        end
        w_acc_next = w_ovf ? w_sat : w_sum[ACC_W-1:0];
    end

    // Accumulator, sticky flag, latched sign/mode and the done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_neg  <= 1'b0;
            r_mode <= MODE_MUL;
            r_done <= 1'b0;
        end else begin
            r_done <= w_acc_en;
            // Clear lands before a same-edge start, so that op sees a zero accumulator.
            if (w_ready && bus.i_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end
            if (w_load) begin
                r_neg  <= w_s_neg ^ w_c_neg;
                r_mode <= bus.i_mode;
            end
            if (w_acc_en) begin
                r_acc <= w_acc_next;
                if (w_ovf) r_ovf <= 1'b1;
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_done     = r_done;
    assign bus.o_result   = r_acc;
    assign bus.o_overflow = r_ovf;

endmodule

// File: tb/tb_eq_serial_mac.sv
// Directed bench for eq_serial_mac: default signed build, unsigned build, 40-bit accumulator build.
module tb_eq_serial_mac;
    import eq_mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    eq_serial_mac_if #(.SAMPLE_W(24), .COEF_W(16), .ACC_W(48)) m();
    eq_serial_mac_if #(.SAMPLE_W(24), .COEF_W(16), .ACC_W(48)) u();
    eq_serial_mac_if #(.SAMPLE_W(24), .COEF_W(16), .ACC_W(40)) w();

    eq_serial_mac #(.SAMPLE_W(24), .COEF_W(16), .ACC_W(48), .SIGNED(1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .bus(m));
    eq_serial_mac #(.SAMPLE_W(24), .COEF_W(16), .ACC_W(48), .SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .bus(u));
    eq_serial_mac #(.SAMPLE_W(24), .COEF_W(16), .ACC_W(40), .SIGNED(1)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .bus(w));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic [23:0] s, input logic [15:0] c,
                         input logic [1:0] md, input logic st, input logic clr);
        case (which)
            0: begin m.i_sample = s; m.i_coefficient = c; m.i_mode = md; m.i_start = st; m.i_clear = clr; end
            1: begin u.i_sample = s; u.i_coefficient = c; u.i_mode = md; u.i_start = st; u.i_clear = clr; end
            default: begin w.i_sample = s; w.i_coefficient = c; w.i_mode = md; w.i_start = st; w.i_clear = clr; end
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return m.o_done;
            1: return u.o_done;
            default: return w.o_done;
        endcase
    endfunction

    function automatic logic get_ready(input int which);
        case (which)
            0: return m.o_ready;
            1: return u.o_ready;
            default: return w.o_ready;
        endcase
    endfunction

    function automatic logic [47:0] get_res(input int which);
        case (which)
            0: return m.o_result;
            1: return u.o_result;
            default: return 48'(w.o_result);
        endcase
    endfunction

    function automatic logic get_ovf(input int which);
        case (which)
            0: return m.o_overflow;
            1: return u.o_overflow;
            default: return w.o_overflow;
        endcase
    endfunction

    // One operation: start with operands, scramble the operand pins, wait (bounded) for done.
    task automatic op(input int which, input logic [23:0] s, input logic [15:0] c,
                      input logic [1:0] md, input logic clr, output int lat,
                      output logic [47:0] res, output logic ovf, output logic busy_ok);
        drive(which, s, c, md, 1'b1, clr);
        step();
        drive(which, 24'hA5A5A5, 16'h5A5A, 2'b01, 1'b0, 1'b0);
        lat = 0;
        busy_ok = 1'b1;
        while (!get_done(which) && lat < 40) begin
            if (get_ready(which)) busy_ok = 1'b0;
            step();
            lat++;
        end
        res = get_res(which);
        ovf = get_ovf(which);
    endtask

    task automatic test_reset();
        drive(0, '0, '0, 2'b00, 1'b0, 1'b0);
        drive(1, '0, '0, 2'b00, 1'b0, 1'b0);
        drive(2, '0, '0, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) step();
        total_cnt++; if (m.o_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", m.o_ready); else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++; if (m.o_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", m.o_ready); else pass_cnt++;
        total_cnt++; if (m.o_done !== 1'b0) $display("FAIL reset_done: got %b exp 0", m.o_done); else pass_cnt++;
        total_cnt++; if (m.o_result !== 48'd0) $display("FAIL reset_result: got %0d exp 0", m.o_result); else pass_cnt++;
        total_cnt++; if (m.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", m.o_overflow); else pass_cnt++;
    endtask

    task automatic test_mul_basic();
        int lat; logic [47:0] res; logic ovf, bok;
        op(0, 24'd3, 16'd5, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (lat !== 17) $display("FAIL mul_latency: got %0d exp 17", lat); else pass_cnt++;
        total_cnt++; if (res !== 48'd15) $display("FAIL mul_3x5: got %0d exp 15", res); else pass_cnt++;
        total_cnt++; if (bok !== 1'b1) $display("FAIL mul_busy_ready: got ready high while busy"); else pass_cnt++;
        total_cnt++; if (m.o_ready !== 1'b1) $display("FAIL mul_ready_with_done: got %b exp 1", m.o_ready); else pass_cnt++;
        step();
        total_cnt++; if (m.o_done !== 1'b0) $display("FAIL done_one_cycle: got %b exp 0", m.o_done); else pass_cnt++;
    endtask

    task automatic test_signed_chain();
        int lat; logic [47:0] res; logic ovf, bok;
        op(0, 24'(-3), 16'd5, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'(-15)) $display("FAIL s_mul: got %0d exp -15", $signed(res)); else pass_cnt++;
        op(0, 24'd7, 16'(-2), MODE_MAC, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'(-29)) $display("FAIL s_mac: got %0d exp -29", $signed(res)); else pass_cnt++;
        op(0, 24'(-4), 16'(-4), MODE_MSUB, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'(-45)) $display("FAIL s_msub: got %0d exp -45", $signed(res)); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL s_ovf: got %b exp 0", ovf); else pass_cnt++;
        op(0, 24'd2, 16'd3, 2'b11, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd6) $display("FAIL reserved_mode: got %0d exp 6", $signed(res)); else pass_cnt++;
    endtask

    task automatic test_corners();
        int lat; logic [47:0] res; logic ovf, bok;
        op(0, 24'h800000, 16'h8000, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd274877906944) $display("FAIL min_x_min: got %0d exp 274877906944", res); else pass_cnt++;
        op(1, 24'hFFFFFF, 16'hFFFF, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd1099494785025) $display("FAIL unsigned_max: got %0d exp 1099494785025", res); else pass_cnt++;
        total_cnt++; if (lat !== 17) $display("FAIL unsigned_latency: got %0d exp 17", lat); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int lat; logic [47:0] res; logic ovf, bok;
        op(2, 24'h800000, 16'h8000, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd274877906944) $display("FAIL sat_first: got %0d exp 274877906944", res); else pass_cnt++;
        op(2, 24'h800000, 16'h8000, MODE_MAC, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd549755813887) $display("FAIL sat_value: got %0d exp 549755813887", res); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL sat_flag: got %b exp 1", ovf); else pass_cnt++;
        op(2, 24'd1, 16'd1, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd1) $display("FAIL sat_next_mul: got %0d exp 1", res); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL sat_sticky: got %b exp 1", ovf); else pass_cnt++;
        drive(2, '0, '0, MODE_MUL, 1'b0, 1'b1);
        step();
        drive(2, '0, '0, MODE_MUL, 1'b0, 1'b0);
        total_cnt++; if (w.o_result !== 40'd0) $display("FAIL clear_result: got %0d exp 0", w.o_result); else pass_cnt++;
        total_cnt++; if (w.o_overflow !== 1'b0) $display("FAIL clear_flag: got %b exp 0", w.o_overflow); else pass_cnt++;
    endtask

    task automatic test_start_clear();
        int lat; logic [47:0] res; logic ovf, bok;
        op(0, 24'd10, 16'd10, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd100) $display("FAIL preload_100: got %0d exp 100", res); else pass_cnt++;
        op(0, 24'd2, 16'd3, MODE_MAC, 1'b1, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd6) $display("FAIL start_clear_mac: got %0d exp 6", res); else pass_cnt++;
    endtask

    task automatic test_busy_start();
        int ndone = 0;
        logic [47:0] res = '0;
        drive(0, 24'd5, 16'd5, MODE_MUL, 1'b1, 1'b0);
        step();
        for (int k = 1; k <= 40; k++) begin
            drive(0, 24'd7, 16'd7, MODE_MAC, (k == 3 || k == 8 || k == 14), (k == 5));
            step();
            if (m.o_done) begin
                ndone++;
                res = m.o_result;
            end
        end
        drive(0, '0, '0, MODE_MUL, 1'b0, 1'b0);
        total_cnt++; if (ndone !== 1) $display("FAIL busy_done_count: got %0d exp 1", ndone); else pass_cnt++;
        total_cnt++; if (res !== 48'd25) $display("FAIL busy_result: got %0d exp 25", res); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; int ndone = 0; logic [47:0] res; logic ovf, bok;
        drive(0, 24'd9, 16'd9, MODE_MUL, 1'b1, 1'b0);
        step();
        drive(0, '0, '0, MODE_MUL, 1'b0, 1'b0);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (m.o_ready !== 1'b1) $display("FAIL midrst_ready: got %b exp 1", m.o_ready); else pass_cnt++;
        total_cnt++; if (m.o_done !== 1'b0) $display("FAIL midrst_done: got %b exp 0", m.o_done); else pass_cnt++;
        total_cnt++; if (m.o_result !== 48'd0) $display("FAIL midrst_result: got %0d exp 0", m.o_result); else pass_cnt++;
        total_cnt++; if (m.o_overflow !== 1'b0) $display("FAIL midrst_ovf: got %b exp 0", m.o_overflow); else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            if (m.o_done) ndone++;
        end
        total_cnt++; if (ndone !== 0) $display("FAIL midrst_no_done: got %0d exp 0", ndone); else pass_cnt++;
        op(0, 24'd4, 16'd4, MODE_MUL, 1'b0, lat, res, ovf, bok);
        total_cnt++; if (res !== 48'd16) $display("FAIL post_rst_mul: got %0d exp 16", res); else pass_cnt++;
        total_cnt++; if (lat !== 17) $display("FAIL post_rst_latency: got %0d exp 17", lat); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_signed_chain();
        test_corners();
        test_saturation();
        test_start_clear();
        test_busy_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
